// File: rtl/regfile_param_if.sv
// Bus bundle between the datapath (master) and the register file (slave):
// write port, two read ports and the bulk-clear handshake.
interface regfile_param_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             writeEnable;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH/8-1:0] byteEnable;
    logic [AW-1:0]    readAddrA;
    logic [WIDTH-1:0] readDataA;
    logic [AW-1:0]    readAddrB;
    logic [WIDTH-1:0] readDataB;
    logic             clearReq;
    logic             busy;

    modport master (
        output writeEnable, writeAddr, writeData, byteEnable,
        output readAddrA, readAddrB, clearReq,
        input  readDataA, readDataB, busy
    );

    modport slave (
        input  writeEnable, writeAddr, writeData, byteEnable,
        input  readAddrA, readAddrB, clearReq,
        output readDataA, readDataB, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte-masked writes, optional zero register
// and a sequenced bulk-clear engine. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_param #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter bit ZERO_EN  = 1'b1,
    parameter int ZERO_IDX = DEPTH - 1
) (
    input logic clk,
    input logic reset,
    regfile_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [AW-1:0]    clearPtr;
    logic             busyReg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] writeMask;
    logic             writeHit;
    logic [WIDTH-1:0] readA;
    logic [WIDTH-1:0] readB;

    always_comb begin
        writeMask = '0;
        for (int k = 0; k < NB; k++) begin
            writeMask[8*k +: 8] = {8{bus.byteEnable[k]}};
        end
    end

    // Writes are only honoured while idle, and never land on the hardwired zero entry.
    assign writeHit = bus.writeEnable && (state == IDLE)
                      && !(ZERO_EN && (bus.writeAddr == ZIDX));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state    <= IDLE;
            clearPtr <= '0;
            busyReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (writeHit) begin
                        mem[bus.writeAddr] <= (mem[bus.writeAddr] & ~writeMask)
                                              | (bus.writeData & writeMask);
                    end
                    if (bus.clearReq) begin
                        state    <= CLEAR;
                        clearPtr <= '0;
                        busyReg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clearPtr] <= '0;
                    clearPtr      <= clearPtr + AW'(1);
                    if (clearPtr == LAST) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    // Zero-register override is applied last so forwarding can never leak into it.
    always_comb begin
        readA = mem[bus.readAddrA];
`ifdef REGFILE_BYPASS_EN
        if (writeHit && (bus.readAddrA == bus.writeAddr)) begin
            readA = (readA & ~writeMask) | (bus.writeData & writeMask);
        end
`endif
        if (ZERO_EN && (bus.readAddrA == ZIDX)) begin
            readA = '0;
        end
    end

    always_comb begin
        readB = mem[bus.readAddrB];
`ifdef REGFILE_BYPASS_EN
        if (writeHit && (bus.readAddrB == bus.writeAddr)) begin
            readB = (readB & ~writeMask) | (bus.writeData & writeMask);
        end
`endif
        if (ZERO_EN && (bus.readAddrB == ZIDX)) begin
            readB = '0;
        end
    end

    assign bus.readDataA = readA;
    assign bus.readDataB = readB;
    assign bus.busy      = busyReg;
endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (64x32, zero register 31);
// expectations follow REGFILE_BYPASS_EN when that macro is defined.
module tb_regfile_param;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   busyCycles;

    regfile_param_if #(.WIDTH(64), .DEPTH(32)) bus ();

    regfile_param #(.WIDTH(64), .DEPTH(32), .ZERO_EN(1'b1), .ZERO_IDX(31)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                                 input logic [7:0] be, input logic [4:0] ra, input logic [4:0] rb,
                                 input logic clr);
        bus.writeEnable = we;
        bus.writeAddr   = wa;
        bus.writeData   = wd;
        bus.byteEnable  = be;
        bus.readAddrA   = ra;
        bus.readAddrB   = rb;
        bus.clearReq    = clr;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 5, 0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        checkOutput("resetReadA", bus.readDataA, 64'h0);
        checkOutput("resetReadB", bus.readDataB, 64'h0);
        checkOutput("resetBusy", {63'h0, bus.busy}, 64'h0);

        // Full-width write, with the same-cycle view depending on forwarding
        applyStimulus(1, 5, 64'hDEADBEEF_CAFEF00D, 8'hFF, 5, 6, 0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("fullWriteSameCycle", bus.readDataA, 64'hDEADBEEF_CAFEF00D);
`else
        checkOutput("fullWriteSameCycle", bus.readDataA, 64'h0);
`endif
        cycle();
        applyStimulus(0, 0, 0, 0, 5, 6, 0);
        checkOutput("fullWriteA", bus.readDataA, 64'hDEADBEEF_CAFEF00D);
        checkOutput("neighbourB", bus.readDataB, 64'h0);

        applyStimulus(1, 5, 64'h11223344_55667788, 8'h0F, 5, 5, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 5, 5, 0);
        checkOutput("lowMaskA", bus.readDataA, 64'hDEADBEEF_55667788);
        checkOutput("lowMaskB", bus.readDataB, 64'hDEADBEEF_55667788);

        applyStimulus(1, 5, 64'hAAAAAAAA_AAAAAAAA, 8'h00, 5, 5, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 5, 5, 0);
        checkOutput("emptyMask", bus.readDataA, 64'hDEADBEEF_55667788);

        applyStimulus(1, 31, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 31, 31, 0);
        checkOutput("zeroRegSameCycle", bus.readDataA, 64'h0);
        cycle();
        applyStimulus(0, 0, 0, 0, 31, 31, 0);
        checkOutput("zeroRegA", bus.readDataA, 64'h0);
        checkOutput("zeroRegB", bus.readDataB, 64'h0);

        applyStimulus(1, 7, 64'h01020304_05060708, 8'hFF, 7, 7, 0);
        cycle();
        applyStimulus(1, 7, 64'h000000AB, 8'h01, 7, 6, 0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("byteBypass", bus.readDataA, 64'h01020304_050607AB);
`else
        checkOutput("byteBypass", bus.readDataA, 64'h01020304_05060708);
`endif
        cycle();
        applyStimulus(0, 0, 0, 0, 7, 7, 0);
        checkOutput("byteWriteLanded", bus.readDataA, 64'h01020304_050607AB);

        for (int i = 0; i < 31; i++) begin
            applyStimulus(1, 5'(i), 64'(i), 8'hFF, 0, 0, 0);
            cycle();
        end
        applyStimulus(0, 0, 0, 0, 17, 30, 0);
        checkOutput("fillReg17", bus.readDataA, 64'd17);
        checkOutput("fillReg30", bus.readDataB, 64'd30);

        // Bulk clear: sample k sees clearPtr == k, so entries below k are already zero
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        cycle();
        busyCycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (!bus.busy) break;
            busyCycles++;
            if (k == 10) begin
                applyStimulus(1, 3, 64'h77, 8'hFF, 9, 10, 1);
                checkOutput("midClearCleared", bus.readDataA, 64'd0);
                checkOutput("midClearPending", bus.readDataB, 64'd10);
            end else begin
                applyStimulus(0, 0, 0, 0, 3, 20, 0);
            end
            cycle();
        end
        checkOutput("busyLength", 64'(busyCycles), 64'd32);
        applyStimulus(1, 2, 64'h55, 8'hFF, 3, 10, 0);
        checkOutput("droppedWriteReg3", bus.readDataA, 64'h0);
        checkOutput("clearedReg10", bus.readDataB, 64'h0);
        cycle();
        applyStimulus(0, 0, 0, 0, 2, 30, 0);
        checkOutput("firstWriteAfterClear", bus.readDataA, 64'h55);
        checkOutput("clearedReg30", bus.readDataB, 64'h0);

        // Reset in the fourth cycle of a clear wipes entries the sweep never reached
        applyStimulus(1, 20, 64'hAA, 8'hFF, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 20, 2, 0);
        cycle();
        cycle();
        cycle();
        checkOutput("busyBeforeAbort", {63'h0, bus.busy}, 64'h1);
        checkOutput("reg20BeforeAbort", bus.readDataA, 64'hAA);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        checkOutput("abortBusy", {63'h0, bus.busy}, 64'h0);
        checkOutput("abortReg20", bus.readDataA, 64'h0);
        checkOutput("abortReg2", bus.readDataB, 64'h0);
        applyStimulus(1, 1, 64'h42, 8'hFF, 1, 1, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 1, 20, 0);
        checkOutput("writeAfterAbort", bus.readDataA, 64'h42);
        checkOutput("abortReg20Later", bus.readDataB, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
